cp0_regfile: RTL and testbench

//  CP0 coprocessor register file: the receiving end of the WB->CP0 bus. Takes the WB commit

---
 rtl/cp0_if.sv | 33 +++
 rtl/cp0_regfile.sv | 149 ++++++++++++++
 tb/tb_cp0_regfile.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_if.sv
// cp0_if: WB->CP0 commit bus and CP0->pipeline return signals.
//  master (pipeline side): drives ws_to_cp0_*, hw_int, tlb_r_*; receives the cp0_* images
//  slave  (cp0_regfile):   the mirror image
interface cp0_if #(
    parameter int TLBNUM = 16
);
    logic [118:0]              ws_to_cp0_bus;
    logic                      ws_to_cp0_valid;
    logic [5:0]                hw_int;
    logic [31:0]               tlb_r_entryhi;
    logic [31:0]               tlb_r_entrylo0;
    logic [31:0]               tlb_r_entrylo1;
    logic [10:0]               cp0_general_bus;
    logic [31:0]               cp0_rdata_bus;
    logic [31:0]               excp_pc;
    logic [31:0]               epc_out;
    logic                      int_req;
    logic [$clog2(TLBNUM)-1:0] cp0_index;
    logic [31:0]               cp0_entryhi;
    logic [31:0]               cp0_entrylo0;
    logic [31:0]               cp0_entrylo1;

    modport slave (
        input  ws_to_cp0_bus, ws_to_cp0_valid, hw_int, tlb_r_entryhi, tlb_r_entrylo0, tlb_r_entrylo1,
        output cp0_general_bus, cp0_rdata_bus, excp_pc, epc_out, int_req, cp0_index,
               cp0_entryhi, cp0_entrylo0, cp0_entrylo1
    );
    modport master (
        output ws_to_cp0_bus, ws_to_cp0_valid, hw_int, tlb_r_entryhi, tlb_r_entrylo0, tlb_r_entrylo1,
        input  cp0_general_bus, cp0_rdata_bus, excp_pc, epc_out, int_req, cp0_index,
               cp0_entryhi, cp0_entrylo0, cp0_entrylo1
    );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 register file fed by the WB commit bus.
//  clk, reset : clock and synchronous active-high reset
//  cp0        : cp0_if.slave -- commit bundle, hw_int and TLB read image in;
//               status/eret, mfc0 data, redirect targets, int_req and TLB write image out
module cp0_regfile #(
    parameter int          TLBNUM    = 16,
    parameter logic [31:0] EXC_ENTRY = 32'hbfc00380
) (
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  cp0
);
    localparam int IW = $clog2(TLBNUM);

    logic          tlbr, tlbp, s1_found, mtc0_we, flush, bd_in;
    logic [IW-1:0] s1_index;
    logic [31:0]   bvaddr, wdata, pc;
    logic [7:0]    addr;
    logic [4:0]    excode_in;
    logic          excp, eret;

    assign tlbr      = cp0.ws_to_cp0_bus[118];
    assign tlbp      = cp0.ws_to_cp0_bus[117];
    assign s1_found  = cp0.ws_to_cp0_bus[116];
    assign s1_index  = cp0.ws_to_cp0_bus[112 +: IW];
    assign mtc0_we   = cp0.ws_to_cp0_bus[111];
    assign bvaddr    = cp0.ws_to_cp0_bus[110:79];
    assign flush     = cp0.ws_to_cp0_bus[78];
    assign addr      = cp0.ws_to_cp0_bus[77:70];
    assign wdata     = cp0.ws_to_cp0_bus[69:38];
    assign excode_in = cp0.ws_to_cp0_bus[37:33];
    assign pc        = cp0.ws_to_cp0_bus[32:1];
    assign bd_in     = cp0.ws_to_cp0_bus[0];

    assign excp = cp0.ws_to_cp0_valid & flush;
    assign eret = flush & ~cp0.ws_to_cp0_valid;

    localparam logic [7:0] A_INDEX = 8'h00, A_LO0 = 8'h10, A_LO1 = 8'h18, A_BADV = 8'h40,
                           A_COUNT = 8'h48, A_HI = 8'h50, A_CMP = 8'h58, A_STATUS = 8'h60,
                           A_CAUSE = 8'h68, A_EPC = 8'h70;

    logic          wr_index, wr_lo0, wr_lo1, wr_count, wr_hi, wr_cmp, wr_status, wr_cause, wr_epc;
    assign wr_index  = mtc0_we && addr == A_INDEX;
    assign wr_lo0    = mtc0_we && addr == A_LO0;
    assign wr_lo1    = mtc0_we && addr == A_LO1;
    assign wr_count  = mtc0_we && addr == A_COUNT;
    assign wr_hi     = mtc0_we && addr == A_HI;
    assign wr_cmp    = mtc0_we && addr == A_CMP;
    assign wr_status = mtc0_we && addr == A_STATUS;
    assign wr_cause  = mtc0_we && addr == A_CAUSE;
    assign wr_epc    = mtc0_we && addr == A_EPC;

    logic [7:0]    im, ip;
    logic          exl, ie, bd, ti, tick, idx_p;
    logic [4:0]    excode;
    logic [31:0]   epc, badvaddr, count, compare, entryhi, entrylo0, entrylo1;
    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ti       <= 1'b0;
            ip       <= '0;
            excode   <= '0;
            epc      <= '0;
            badvaddr <= '0;
            count    <= '0;
            compare  <= '0;
            tick     <= 1'b0;
            idx_p    <= 1'b0;
            idx      <= '0;
            entryhi  <= '0;
            entrylo0 <= '0;
            entrylo1 <= '0;
        end else begin
            tick    <= ~tick;
            count   <= wr_count ? wdata : count + {31'b0, tick};
            compare <= wr_cmp ? wdata : compare;
            ti      <= wr_cmp ? 1'b0 : (count == compare) | ti;
            // Timer interrupt shares IP7 with hw_int[5]; sampled from the registered TI
            ip[7:2] <= {cp0.hw_int[5] | ti, cp0.hw_int[4:0]};
            if (excp) begin
                exl    <= 1'b1;
                excode <= excode_in;
                // Nested exception keeps the original return point
                if (!exl) begin
                    bd  <= bd_in;
                    epc <= bd_in ? pc - 32'd4 : pc;
                end
                if (excode_in >= 5'd1 && excode_in <= 5'd5) badvaddr <= bvaddr;
            end else if (eret) begin
                exl <= 1'b0;
            end else begin
                if (wr_status) {im, exl, ie} <= {wdata[15:8], wdata[1:0]};
                if (wr_cause) ip[1:0] <= wdata[9:8];
                if (wr_epc) epc <= wdata;
            end
            if (tlbp) begin
                idx_p <= ~s1_found;
                if (s1_found) idx <= s1_index;
            end else if (wr_index) begin
                idx <= wdata[IW-1:0];
            end
            if (tlbr) begin
                entryhi  <= cp0.tlb_r_entryhi;
                entrylo0 <= cp0.tlb_r_entrylo0;
                entrylo1 <= cp0.tlb_r_entrylo1;
            end else begin
                if (wr_hi) entryhi <= wdata & 32'hffffe0ff;
                if (wr_lo0) entrylo0 <= wdata & 32'h03ffffff;
                if (wr_lo1) entrylo1 <= wdata & 32'h03ffffff;
            end
        end
    end

    logic [31:0] status, cause, index_v;
    assign status  = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause   = {bd, ti, 14'b0, ip, 1'b0, excode, 2'b0};
    assign index_v = {idx_p, {(31-IW){1'b0}}, idx};

    always_comb begin
        cp0.cp0_rdata_bus = '0;
        case (addr)
            A_INDEX:  cp0.cp0_rdata_bus = index_v;
            A_LO0:    cp0.cp0_rdata_bus = entrylo0;
            A_LO1:    cp0.cp0_rdata_bus = entrylo1;
            A_BADV:   cp0.cp0_rdata_bus = badvaddr;
            A_COUNT:  cp0.cp0_rdata_bus = count;
            A_HI:     cp0.cp0_rdata_bus = entryhi;
            A_CMP:    cp0.cp0_rdata_bus = compare;
            A_STATUS: cp0.cp0_rdata_bus = status;
            A_CAUSE:  cp0.cp0_rdata_bus = cause;
            A_EPC:    cp0.cp0_rdata_bus = epc;
            default:  cp0.cp0_rdata_bus = '0;
        endcase
    end

    assign cp0.cp0_general_bus = {eret, im, exl, ie};
    assign cp0.excp_pc         = EXC_ENTRY;
    assign cp0.epc_out         = epc;
    assign cp0.int_req         = ie & ~exl & |(ip & im);
    assign cp0.cp0_index       = idx;
    assign cp0.cp0_entryhi     = entryhi;
    assign cp0.cp0_entrylo0    = entrylo0;
    assign cp0.cp0_entrylo1    = entrylo1;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: self-checking bench for cp0_regfile (mtc0 vector table plus timer,
//  exception/eret, TLB and Count corner-case sequences), scoreboard-compared.
module tb_cp0_regfile;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        tlbr;
        logic        tlbp;
        logic        s1_found;
        logic [3:0]  s1_index;
        logic        mtc0_we;
        logic [31:0] bvaddr;
        logic        flush;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [4:0]  excode;
        logic [31:0] pc;
        logic        bd;
    } bus_t;

    bus_t        b = '0;
    logic        valid = 1'b0;
    logic [5:0]  hw = '0;
    logic [31:0] r_hi = '0, r_lo0 = '0, r_lo1 = '0;

    cp0_if ifc ();
    assign ifc.ws_to_cp0_bus   = b;
    assign ifc.ws_to_cp0_valid = valid;
    assign ifc.hw_int          = hw;
    assign ifc.tlb_r_entryhi   = r_hi;
    assign ifc.tlb_r_entrylo0  = r_lo0;
    assign ifc.tlb_r_entrylo1  = r_lo1;

    cp0_regfile dut (.clk(clk), .reset(reset), .cp0(ifc.slave));

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sbq[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic push_exp(input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [31:0] act);
        exp_t e;
        n_vec++;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %08h want <none>", act);
        end else begin
            e = sbq.pop_front();
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %08h want %08h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic rd_mask(input string name, input logic [7:0] a, input logic [31:0] m,
                           input logic [31:0] exp);
        b.addr = a;
        push_exp(name, exp);
        #1;
        chk(ifc.cp0_rdata_bus & m);
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        rd_mask(name, a, 32'hffffffff, exp);
    endtask

    task automatic out(input string name, input logic [31:0] act, input logic [31:0] exp);
        push_exp(name, exp);
        chk(act);
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        b = '0;
        b.mtc0_we = 1'b1;
        b.addr = a;
        b.wdata = d;
        step();
        b = '0;
    endtask

    task automatic do_reset();
        b = '0;
        valid = 1'b0;
        hw = '0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic exception(input logic [4:0] code, input logic [31:0] epc_in, input logic bdi,
                             input logic [31:0] bva);
        b = '0;
        b.flush = 1'b1;
        b.excode = code;
        b.pc = epc_in;
        b.bd = bdi;
        b.bvaddr = bva;
        valid = 1'b1;
        step();
        b = '0;
        valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[$];
        logic [31:0] prev;
        int          n;
        logic        found, chg;
        tbl.push_back('{"compare_wr",  8'h58, 32'h7fff0000, 32'h7fff0000});
        tbl.push_back('{"cause_wr",    8'h68, 32'hffffffff, 32'h00000300});
        tbl.push_back('{"epc_wr",      8'h70, 32'hffffffff, 32'hffffffff});
        tbl.push_back('{"entryhi_wr",  8'h50, 32'hffffffff, 32'hffffe0ff});
        tbl.push_back('{"entrylo0_wr", 8'h10, 32'hffffffff, 32'h03ffffff});
        tbl.push_back('{"entrylo1_wr", 8'h18, 32'h12345678, 32'h02345678});
        tbl.push_back('{"index_wr",    8'h00, 32'hffffffff, 32'h0000000f});
        tbl.push_back('{"badvaddr_ro", 8'h40, 32'hffffffff, 32'h00000000});
        tbl.push_back('{"unmapped_rd", 8'h08, 32'hffffffff, 32'h00000000});
        tbl.push_back('{"status_wr1",  8'h60, 32'hffffffff, 32'h0040ff03});
        tbl.push_back('{"status_wr0",  8'h60, 32'h00000000, 32'h00400000});
        tbl.push_back('{"cause_wr0",   8'h68, 32'h00000000, 32'h00000000});

        // Reset state, then 10 idle cycles
        do_reset();
        rd("rst_status", 8'h60, 32'h00400000);
        rd("rst_cause", 8'h68, 32'h0);
        rd("rst_count", 8'h48, 32'h0);
        rd("rst_epc", 8'h70, 32'h0);
        rd("rst_badvaddr", 8'h40, 32'h0);
        rd("rst_index", 8'h00, 32'h0);
        rd("rst_entryhi", 8'h50, 32'h0);
        rd("rst_compare", 8'h58, 32'h0);
        out("rst_int_req", 32'(ifc.int_req), 32'h0);
        out("rst_excp_pc", ifc.excp_pc, 32'hbfc00380);
        out("rst_general", 32'(ifc.cp0_general_bus), 32'h0);
        out("rst_epc_out", ifc.epc_out, 32'h0);
        idle(10);
        rd("idle_count", 8'h48, 32'h5);
        rd("idle_status", 8'h60, 32'h00400000);
        rd("idle_epc", 8'h70, 32'h0);
        rd("idle_index", 8'h00, 32'h0);
        out("idle_int_req", 32'(ifc.int_req), 32'h0);

        // mtc0 write masks: write, let IP settle one cycle, read back
        foreach (tbl[i]) begin
            mtc0(tbl[i].addr, tbl[i].wdata);
            idle(1);
            rd(tbl[i].name, tbl[i].addr, tbl[i].exp);
        end
        hw = 6'b000101;
        step();
        rd_mask("hw_int_ip", 8'h68, 32'h0000fc00, 32'h00001400);
        hw = '0;

        // Timer interrupt
        do_reset();
        mtc0(8'h58, 32'd3);
        mtc0(8'h48, 32'd0);
        mtc0(8'h60, 32'h00008001);
        rd("status_ie_im7", 8'h60, 32'h00408001);
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 30 && !found; i++) begin
            step();
            b.addr = 8'h68;
            #1;
            if (ifc.cp0_rdata_bus[30]) begin
                found = 1'b1;
                n = i;
            end
        end
        out("ti_latency", 32'(n), 32'd6);
        rd("ti_count", 8'h48, 32'd3);
        out("ti_int_req_lag", 32'(ifc.int_req), 32'h0);
        step();
        out("ti_int_req", 32'(ifc.int_req), 32'h1);
        mtc0(8'h58, 32'd10);
        rd_mask("ti_clear", 8'h68, 32'h40000000, 32'h0);
        step();
        out("ti_clear_int_req", 32'(ifc.int_req), 32'h0);
        mtc0(8'h60, 32'h0);

        // Exception with branch delay, nested exception, eret
        exception(5'd4, 32'hbfc00100, 1'b1, 32'h1);
        rd("exc_epc", 8'h70, 32'hbfc000fc);
        rd_mask("exc_cause", 8'h68, 32'h8000007c, 32'h80000010);
        rd("exc_badvaddr", 8'h40, 32'h1);
        rd("exc_status", 8'h60, 32'h00400002);
        out("exc_general", 32'(ifc.cp0_general_bus), 32'h002);
        out("exc_epc_out", ifc.epc_out, 32'hbfc000fc);
        exception(5'd8, 32'h00000200, 1'b0, 32'h0000dead);
        rd("exc2_epc", 8'h70, 32'hbfc000fc);
        rd_mask("exc2_cause", 8'h68, 32'h8000007c, 32'h80000020);
        rd("exc2_badvaddr", 8'h40, 32'h1);
        b = '0;
        b.flush = 1'b1;
        #1;
        out("eret_flush", 32'(ifc.cp0_general_bus[10]), 32'h1);
        step();
        b = '0;
        #1;
        out("eret_flush_off", 32'(ifc.cp0_general_bus[10]), 32'h0);
        rd("eret_status", 8'h60, 32'h00400000);

        // TLB probe / read
        b = '0;
        b.tlbp = 1'b1;
        b.s1_found = 1'b1;
        b.s1_index = 4'd7;
        step();
        b = '0;
        rd("tlbp_found", 8'h00, 32'h00000007);
        out("tlbp_cp0_index", 32'(ifc.cp0_index), 32'h7);
        mtc0(8'h00, 32'h0);
        b.tlbp = 1'b1;
        step();
        b = '0;
        rd("tlbp_miss", 8'h00, 32'h80000000);
        b.tlbp = 1'b1;
        b.s1_found = 1'b1;
        b.s1_index = 4'd3;
        step();
        b = '0;
        rd("tlbp_hit_again", 8'h00, 32'h00000003);
        r_hi = 32'habcde042;
        r_lo0 = 32'h01234567;
        r_lo1 = 32'h00abcdef;
        b.tlbr = 1'b1;
        step();
        b = '0;
        rd("tlbr_entryhi", 8'h50, 32'habcde042);
        rd("tlbr_entrylo0", 8'h10, 32'h01234567);
        rd("tlbr_entrylo1", 8'h18, 32'h00abcdef);
        out("tlbr_cp0_entryhi", ifc.cp0_entryhi, 32'habcde042);
        out("tlbr_cp0_entrylo1", ifc.cp0_entrylo1, 32'h00abcdef);

        // Count wrap and mtc0 Count on an increment cycle
        mtc0(8'h48, 32'hffffffff);
        idle(2);
        rd("count_wrap", 8'h48, 32'h0);
        prev = ifc.cp0_rdata_bus;
        chg = 1'b0;
        for (int i = 0; i < 4 && !chg; i++) begin
            step();
            b.addr = 8'h48;
            #1;
            chg = ifc.cp0_rdata_bus != prev;
            prev = ifc.cp0_rdata_bus;
        end
        out("count_increments", 32'(chg), 32'h1);
        step();
        mtc0(8'h48, 32'h55);
        rd("count_override", 8'h48, 32'h55);
        step();
        rd("count_hold", 8'h48, 32'h55);
        step();
        rd("count_inc", 8'h48, 32'h56);

        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
